// File: rtl/dmem_pkg.sv
// Shared types and byte-enable helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam int N_LEGAL_BE = 7;

    // Byte, aligned halfword and full word patterns only.
    localparam logic [N_LEGAL_BE-1:0][3:0] LEGAL_BE = {
        4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001
    };

    function automatic logic be_legal(input logic [3:0] be);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LEGAL_BE; i++) begin
            if (be == LEGAL_BE[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [1:0] be_low_lane(input logic [3:0] be);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (be[i]) lane = 2'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous byte-masked write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one request at a time, response after LATENCY cycles,
// byte-masked stores committed at accept, access errors flagged in the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    dmem_req_t   req_q, req_d;

    dmem_req_t   req_in;
    logic [31:0] req_offset, lat_offset, rd_data;
    logic [AW-1:0] rd_idx;
    logic        req_err, accept, wr_en;
    logic        unused_req_bits;

    assign req_in     = '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata};
    assign req_offset = req_addr - BASE_ADDR;
    assign lat_offset = req_q.addr - BASE_ADDR;

    // Offset compare is unsigned, so addresses below BASE_ADDR wrap high and fail too.
    assign req_err = (req_offset >= SPAN) || !be_legal(req_be) ||
                     (req_addr[1:0] != be_low_lane(req_be));

    assign accept = req_valid && (state_q == IDLE);
    assign wr_en  = accept && req_we && !req_err;

    // In IDLE the read port follows the live request so a LATENCY==1 load can sample at accept.
    assign rd_idx = (state_q == IDLE) ? req_offset[AW+1:2] : lat_offset[AW+1:2];

    // Store data and enables are consumed at accept; the latched copies are not read back.
    assign unused_req_bits = ^{req_q.be, req_q.wdata, lat_offset[31:AW+2], lat_offset[1:0]};

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (req_offset[AW+1:2]),
        .wr_be   (req_be),
        .wr_data (req_wdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = req_in;
                    err_d = req_err;
                    cnt_d = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_err_d   = req_err;
                        rsp_rdata_d = (req_err || req_we) ? 32'h0 : rd_data;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = RESP;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || req_q.we) ? 32'h0 : rd_data;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
